// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU sharing controller.
//   - ALU operand/opcode widths
//   - opcode constants (opcodes 8..F are passed through untouched)
//   - flag bit indices within alu_flags / alu_en / flag register
//   - arbitration FSM state encoding
package alu_pkg;

    localparam int unsigned DW  = 16;
    localparam int unsigned OPW = 4;

    localparam logic [OPW-1:0] OP_ADD    = 4'h0;
    localparam logic [OPW-1:0] OP_SUB    = 4'h1;
    localparam logic [OPW-1:0] OP_XOR    = 4'h2;
    localparam logic [OPW-1:0] OP_RED    = 4'h3;
    localparam logic [OPW-1:0] OP_SLL    = 4'h4;
    localparam logic [OPW-1:0] OP_SRA    = 4'h5;
    localparam logic [OPW-1:0] OP_ROR    = 4'h6;
    localparam logic [OPW-1:0] OP_PADDSB = 4'h7;
    localparam logic [OPW-1:0] OP_LW     = 4'h8;
    localparam logic [OPW-1:0] OP_SW     = 4'h9;
    localparam logic [OPW-1:0] OP_LLB    = 4'hA;
    localparam logic [OPW-1:0] OP_LHB    = 4'hB;

    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: bundle of all signals around the ALU sharing controller.
//   r0_* / r1_*      : requester handshakes (valid/lock/op/a/b in, ready out)
//   alu_*            : ALU drive (op/in1/in2) and ALU return (out/flags/en)
//   resp_*           : one-cycle-latency registered response
//   flag_z/v/n       : architectural flag register
// Modports: slave = controller side, master = requester/ALU environment side.
interface alu_share_ctrl_if;
    import alu_pkg::*;

    logic           r0_valid, r0_lock, r0_ready;
    logic [OPW-1:0] r0_op;
    logic [DW-1:0]  r0_a, r0_b;
    logic           r1_valid, r1_lock, r1_ready;
    logic [OPW-1:0] r1_op;
    logic [DW-1:0]  r1_a, r1_b;

    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_in1, alu_in2, alu_out;
    logic [2:0]     alu_flags, alu_en;

    logic           resp_valid, resp_id;
    logic [DW-1:0]  resp_data;
    logic           flag_z, flag_v, flag_n;

    modport slave (
        input  r0_valid, r0_lock, r0_op, r0_a, r0_b,
        input  r1_valid, r1_lock, r1_op, r1_a, r1_b,
        input  alu_out, alu_flags, alu_en,
        output r0_ready, r1_ready,
        output alu_op, alu_in1, alu_in2,
        output resp_valid, resp_id, resp_data,
        output flag_z, flag_v, flag_n
    );

    modport master (
        output r0_valid, r0_lock, r0_op, r0_a, r0_b,
        output r1_valid, r1_lock, r1_op, r1_a, r1_b,
        output alu_out, alu_flags, alu_en,
        input  r0_ready, r1_ready,
        input  alu_op, alu_in1, alu_in2,
        input  resp_valid, resp_id, resp_data,
        input  flag_z, flag_v, flag_n
    );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with ownership lock.
//   clk, rst  : clock, synchronous active-high reset
//   valid_i   : request per requester
//   lock_i    : requester keeps ownership after its accepted op
//   gnt_o     : one-hot (or zero) grant, combinational from state and valids;
//               a grant is an accept since it only rises with valid
module rr_arb2
    import alu_pkg::*;
#(
    parameter int RR_START = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid_i,
    input  logic [1:0] lock_i,
    output logic [1:0] gnt_o
);

    arb_state_e state_q;
    logic       rr_ptr_q;

    always_comb begin
        gnt_o = '0;
        if (!rst) begin
            unique case (state_q)
                ST_ARB: begin
                    if (&valid_i) gnt_o[rr_ptr_q] = 1'b1;
                    else          gnt_o           = valid_i;
                end
                ST_LOCK0: gnt_o[0] = valid_i[0];
                ST_LOCK1: gnt_o[1] = valid_i[1];
                default:  gnt_o    = '0;
            endcase
        end
    end

    // Idle cycles while locked leave the state untouched, so ownership survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ARB;
            rr_ptr_q <= (RR_START != 0);
        end else if (gnt_o[0]) begin
            rr_ptr_q <= 1'b1;
            state_q  <= lock_i[0] ? ST_LOCK0 : ST_ARB;
        end else if (gnt_o[1]) begin
            rr_ptr_q <= 1'b0;
            state_q  <= lock_i[1] ? ST_LOCK1 : ST_ARB;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one 16-bit ALU between the execute stage (r0) and
// the address/branch-target unit (r1).
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_share_ctrl_if.slave (requesters, ALU, response, flags)
//   perf_*   : saturating grant/conflict counters, present only when
//              ALU_SHARE_PERF_EN is defined
// Only r0 accepts write the ZVN flag register, bit-wise gated by alu_en.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int RR_START = 0
) (
    input  logic              clk,
    input  logic              rst,
    alu_share_ctrl_if.slave   bus
`ifdef ALU_SHARE_PERF_EN
    ,
    output logic [15:0]       perf_grant0,
    output logic [15:0]       perf_grant1,
    output logic [15:0]       perf_conflict
`endif
);

    logic [1:0]    gnt;
    logic          resp_valid_q, resp_id_q;
    logic [DW-1:0] resp_data_q;
    logic [2:0]    flags_q;

    rr_arb2 #(.RR_START(RR_START)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid_i ({bus.r1_valid, bus.r0_valid}),
        .lock_i  ({bus.r1_lock,  bus.r0_lock}),
        .gnt_o   (gnt)
    );

    assign bus.r0_ready = gnt[0];
    assign bus.r1_ready = gnt[1];

    always_comb begin
        bus.alu_op  = '0;
        bus.alu_in1 = '0;
        bus.alu_in2 = '0;
        if (gnt[0]) begin
            bus.alu_op  = bus.r0_op;
            bus.alu_in1 = bus.r0_a;
            bus.alu_in2 = bus.r0_b;
        end else if (gnt[1]) begin
            bus.alu_op  = bus.r1_op;
            bus.alu_in1 = bus.r1_a;
            bus.alu_in2 = bus.r1_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
            flags_q      <= '0;
        end else begin
            resp_valid_q <= |gnt;
            if (|gnt) begin
                resp_id_q   <= gnt[1];
                resp_data_q <= bus.alu_out;
            end
            if (gnt[0]) begin
                for (int unsigned k = 0; k < 3; k++) begin
                    if (bus.alu_en[k]) flags_q[k] <= bus.alu_flags[k];
                end
            end
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.flag_z     = flags_q[FLAG_Z];
    assign bus.flag_v     = flags_q[FLAG_V];
    assign bus.flag_n     = flags_q[FLAG_N];

`ifdef ALU_SHARE_PERF_EN
    logic [15:0] pg0_q, pg1_q, pc_q;
    logic        conflict;

    assign conflict = (bus.r0_valid & ~gnt[0]) | (bus.r1_valid & ~gnt[1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            pg0_q <= '0;
            pg1_q <= '0;
            pc_q  <= '0;
        end else begin
            if (gnt[0] && pg0_q != '1) pg0_q <= pg0_q + 16'd1;
            if (gnt[1] && pg1_q != '1) pg1_q <= pg1_q + 16'd1;
            if (conflict && pc_q != '1) pc_q <= pc_q + 16'd1;
        end
    end

    assign perf_grant0   = pg0_q;
    assign perf_grant1   = pg1_q;
    assign perf_conflict = pc_q;
`endif

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
Arbitrates the single 16-bit ALU between two requesters: requester 0 is the execute stage and requester 1 is the address/branch-target unit. Grants are round-robin, with an optional lock that holds ownership across a multi-op sequence. The block drives the ALU inputs, registers the result into a one-cycle-latency response, and owns the architectural ZVN flag register. Only requester-0 operations update the flag register, gated by the ALU's per-flag enables.

Parameters:
DW, 16, operand/result width (fixed by the ALU; not user-tunable)
OPW, 4, opcode width
RR_START, 0, requester favoured first after reset (0 or 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
r0_valid  in  1  requester 0 has an op
r0_lock  in  1  requester 0 keeps ownership after this op
r0_op  in  4  opcode
r0_a  in  16  operand 1
r0_b  in  16  operand 2
r0_ready  out  1  grant; op accepted this cycle when r0_valid and r0_ready are both high
r1_valid, r1_lock, r1_op, r1_a, r1_b, r1_ready  same as r0_*, for requester 1
alu_op  out  4  to ALU Opcode
alu_in1  out  16  to ALU_In1
alu_in2  out  16  to ALU_In2
alu_out  in  16  from ALU_Out
alu_flags  in  3  from ALU Flags: [2]=Z, [1]=V, [0]=N
alu_en  in  3  from ALU en: per-flag write enables, same bit order
resp_valid  out  1  result available (one-cycle pulse per accepted op)
resp_id  out  1  requester that owns resp_data
resp_data  out  16  registered ALU result
flag_z, flag_v, flag_n  out  1 each  architectural flag register

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM enters ARB.
  - rr_ptr = RR_START.
  - Flag register = 000.
- Reset asserted mid-operation: any in-flight response is dropped, and resp_valid is 0 in the following cycle.
- FSM states and transitions:
  - ARB: grant one requester per cycle.
    - If only one requester is valid, it is granted.
    - If both are valid, the grant goes to rr_ptr.
    - After an accepted op, rr_ptr = the other requester.
    - If the accepted op has lock=1, go to LOCK0 or LOCK1 matching the granted requester.
  - LOCKn: only requester n may be granted.
    - The other requester's ready stays 0 even if it is valid.
    - Stay in LOCKn while accepted ops carry lock=1.
    - An accepted op with lock=0 returns to ARB and sets rr_ptr = the other requester.
    - If requester n deasserts valid while locked, stay in LOCKn (ownership is not lost by idling).
- Handshake:
  - rN_ready is combinational from state and valids.
  - ready is asserted only for the granted requester, and only when that requester's valid is high.
  - No two readies are ever high in the same cycle.
- Datapath:
  - In a grant cycle, alu_op/alu_in1/alu_in2 = the granted requester's op/a/b.
  - With no grant, alu_op/alu_in1/alu_in2 = 0.
- Latency and throughput:
  - An op accepted in cycle t produces resp_valid=1, resp_id=owner and resp_data=alu_out (sampled at t) in cycle t+1.
  - Back-to-back ops are accepted every cycle with no bubbles.
- Flag register: on the clock edge ending an accept cycle from requester 0, for each bit k, flag[k] <= alu_en[k] ? alu_flags[k] : flag[k]. Requester-1 ops never modify flags.
- Opcode 8..F: the block passes these opcodes through with no special handling. The flags update only where alu_en is set.

Optional Feature:
- Macro: ALU_SHARE_PERF_EN.
- Defined:
  - Adds outputs perf_grant0 [15:0], perf_grant1 [15:0] and perf_conflict [15:0].
  - perf_grant0 and perf_grant1 count accepted ops per requester.
  - perf_conflict counts cycles where a requester was valid but not ready.
  - All counters are saturating, and reset to 0 on rst.
- Undefined: none of these ports or counters exist, and all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants (ADD=0, SUB=1, XOR=2, RED=3, SLL=4, SRA=5, ROR=6, PADDSB=7, LW=8, SW=9, LLB=A, LHB=B);
  - flag bit indices FLAG_Z=2, FLAG_V=1, FLAG_N=0;
  - the FSM state encoding.
- Sub-module rr_arb2: the 2-way round-robin grant with lock input. It is the natural split and is reusable by the memory arbiter.

Test Plan:
1. Reset, then r0 ADD a=0x7FFF b=0x0001. Required: r0_ready=1; next cycle resp_valid=1, resp_id=0, resp_data=0x8000; flags Z=0 V=1 N=1.
2. With flags ZVN=111, r0 XOR a=b=0x1234 with the ALU returning en=100. Required: Z=1, V and N unchanged at 1; then r1 SUB 5-5 → flags unchanged and resp_id=1.
3. Both valid every cycle with RR_START=0. Required: grants alternate 0,1,0,1 and resp_id follows one cycle later.
4. r1 issues with lock=1, then lock=0 while r0 is continuously valid. Required: r0_ready=0 for both r1 ops, r0 is granted in the next cycle, and r1 is not granted in the cycle after that.
5. Locked r0 drops valid for 3 cycles while r1 is valid. Required: r1_ready stays 0 throughout; r0 resumes with its grant intact.
6. Assert rst in the cycle after an accept. Required: resp_valid=0, flags=000, FSM in ARB.
